// File: rtl/record_playback_if.sv
// Control/status bundle between the recording top and the playback reader.
//   master: drives Tick, write port (Wr_*), Clr/Play/Stop/Loop; observes LED/status.
//   slave : the playback reader; drives LED, Busy, Done, Full, Count.
interface record_playback_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DUR_W  = 16,
  parameter int unsigned LED_W  = 4
) ();
  logic              Tick;
  logic              Wr_En;
  logic [LED_W-1:0]  Wr_Led;
  logic [DUR_W-1:0]  Wr_Dur;
  logic              Clr;
  logic              Play;
  logic              Stop;
  logic              Loop;
  logic [LED_W-1:0]  LED;
  logic              Busy;
  logic              Done;
  logic              Full;
  logic [ADDR_W:0]   Count;

  modport master (
    output Tick, Wr_En, Wr_Led, Wr_Dur, Clr, Play, Stop, Loop,
    input  LED, Busy, Done, Full, Count
  );

  modport slave (
    input  Tick, Wr_En, Wr_Led, Wr_Dur, Clr, Play, Stop, Loop,
    output LED, Busy, Done, Full, Count
  );
endinterface

// File: rtl/record_playback.sv
// Playback reader: buffers (LED pattern, duration) pairs and replays them onto
// LED, holding each entry for its duration in 0.1 ms ticks.
//   Sys_CLK : system clock (rising edge)
//   Sys_RST : async active-low reset
//   bus     : slave side of record_playback_if (Tick, write port, Clr/Play/Stop/Loop
//             in; LED, Busy, Done, Full, Count out, all registered)
module record_playback #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DUR_W  = 16,
  parameter int unsigned LED_W  = 4
) (
  input  logic             Sys_CLK,
  input  logic             Sys_RST,
  record_playback_if.slave bus
);

  localparam int unsigned CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [LED_W-1:0]  r_led_mem [DEPTH];
  logic [DUR_W-1:0]  r_dur_mem [DEPTH];

  logic [1:0]        r_state,   w_state_nx;
  logic [ADDR_W-1:0] r_rd_addr, w_rd_addr_nx;
  logic [DUR_W-1:0]  r_remain,  w_remain_nx;
  logic [LED_W-1:0]  r_led,     w_led_nx;
  logic [CNT_W-1:0]  r_count,   w_count_nx;
  logic              r_busy,    w_busy_nx;
  logic              r_done,    w_done_nx;
  logic              r_full,    w_full_nx;

  logic              w_wr_acc;
  logic              w_last;
  logic [LED_W-1:0]  w_rd_led;
  logic [DUR_W-1:0]  w_rd_dur;

  // Clr beats Wr_En; writes only land while idle and not full
  assign w_wr_acc = (r_state == S_IDLE) && bus.Wr_En && !r_full && !bus.Clr;
  assign w_last   = ({1'b0, r_rd_addr} == (r_count - CNT_W'(1)));
  assign w_rd_led = r_led_mem[r_rd_addr];
  assign w_rd_dur = r_dur_mem[r_rd_addr];

  // Entry storage, no reset needed: Count gates what is ever read
  always_ff @(posedge Sys_CLK) begin
    if (w_wr_acc) begin
      r_led_mem[r_count[ADDR_W-1:0]] <= bus.Wr_Led;
      r_dur_mem[r_count[ADDR_W-1:0]] <= bus.Wr_Dur;
    end
  end

  // State and output registers
  always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
    if (!Sys_RST) begin
      r_state   <= S_IDLE;
      r_rd_addr <= '0;
      r_remain  <= '0;
      r_led     <= '0;
      r_count   <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_full    <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_rd_addr <= w_rd_addr_nx;
      r_remain  <= w_remain_nx;
      r_led     <= w_led_nx;
      r_count   <= w_count_nx;
      r_busy    <= w_busy_nx;
      r_done    <= w_done_nx;
      r_full    <= w_full_nx;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    w_state_nx   = r_state;
    w_rd_addr_nx = r_rd_addr;
    w_remain_nx  = r_remain;
    w_led_nx     = r_led;
    w_count_nx   = r_count;
    w_done_nx    = 1'b0;

    if (r_state == S_IDLE) begin
      if (bus.Clr)       w_count_nx = '0;
      else if (w_wr_acc) w_count_nx = r_count + CNT_W'(1);
    end

    case (r_state)
      S_IDLE: begin
        w_led_nx = '0;
        if (!bus.Stop && bus.Play) begin
          if (r_count != '0) begin
            w_state_nx   = S_LOAD;
            w_rd_addr_nx = '0;
          end else begin
            // Empty buffer: report an immediate, empty replay
            w_done_nx = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (bus.Stop) begin
          w_state_nx = S_IDLE;
          w_led_nx   = '0;
        end else begin
          w_state_nx  = S_PLAY;
          w_led_nx    = w_rd_led;
          w_remain_nx = (w_rd_dur == '0) ? DUR_W'(1) : w_rd_dur;
        end
      end
      S_PLAY: begin
        if (bus.Stop) begin
          w_state_nx = S_IDLE;
          w_led_nx   = '0;
        end else if (bus.Tick) begin
          if (r_remain == DUR_W'(1)) begin
            if (!w_last) begin
              w_rd_addr_nx = r_rd_addr + ADDR_W'(1);
              w_state_nx   = S_LOAD;
            end else if (bus.Loop) begin
              w_rd_addr_nx = '0;
              w_state_nx   = S_LOAD;
            end else begin
              w_state_nx = S_DONE;
              w_led_nx   = '0;
              w_done_nx  = 1'b1;
            end
          end else begin
            w_remain_nx = r_remain - DUR_W'(1);
          end
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
        w_led_nx   = '0;
      end
      default: begin
        w_state_nx = S_IDLE;
        w_led_nx   = '0;
      end
    endcase

    w_busy_nx = (w_state_nx == S_LOAD) || (w_state_nx == S_PLAY);
    w_full_nx = (w_count_nx == DEPTH_C);
  end

  assign bus.LED   = r_led;
  assign bus.Busy  = r_busy;
  assign bus.Done  = r_done;
  assign bus.Full  = r_full;
  assign bus.Count = r_count;

endmodule

// File: tb/tb_record_playback.sv
// Bench for record_playback: random (LED, duration) buffers are replayed; the
// expected sequence of (pattern, ticks held) segments and Done pulses is queued
// from a buffer model, and a monitor reconstructs segments from LED/Busy/Tick.
module tb_record_playback;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DUR_W  = 16;
  localparam int unsigned LED_W  = 4;

  typedef struct {
    bit               is_done;
    logic [LED_W-1:0] led;
    int unsigned      ticks;
  } ev_t;

  typedef struct {
    logic [LED_W-1:0] led;
    int unsigned      dur;
  } ent_t;

  logic Sys_CLK = 1'b0;
  logic Sys_RST = 1'b1;
  always #5 Sys_CLK = ~Sys_CLK;

  record_playback_if #(.ADDR_W(ADDR_W), .DUR_W(DUR_W), .LED_W(LED_W)) bus ();

  record_playback #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DUR_W(DUR_W), .LED_W(LED_W)) dut (
    .Sys_CLK (Sys_CLK),
    .Sys_RST (Sys_RST),
    .bus     (bus)
  );

  ev_t  exp_q[$];
  ent_t m_ent[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  bit   tick_en = 1'b0;
  int   gap = 0;
  int   seg_count = 0;
  int unsigned      cur_ticks = 0;
  logic [LED_W-1:0] prev_led = '0;
  bit               prev_busy = 1'b0;

  function automatic void chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, expv);
    end
  endfunction

  function automatic void mon_cmp(bit is_done, logic [LED_W-1:0] led, int unsigned ticks);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got done=%0d led=%0d ticks/busy=%0d, required no event",
               is_done, led, ticks);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_done != is_done || e.led != led || e.ticks != ticks) begin
      errors++;
      $display("FAIL playback_event: got done=%0d led=%0d ticks/busy=%0d, required done=%0d led=%0d ticks/busy=%0d",
               is_done, led, ticks, e.is_done, e.led, e.ticks);
    end
  endfunction

  function automatic void push_ev(bit d, logic [LED_W-1:0] l, int unsigned t);
    ev_t e;
    e.is_done = d;
    e.led     = l;
    e.ticks   = t;
    exp_q.push_back(e);
  endfunction

  // Monitor: a segment is a run of constant nonzero LED while Busy; ticks consumed
  // while it was shown are attributed to it. Done events must show LED=0, Busy=0.
  always @(posedge Sys_CLK) begin
    #1;
    if (!mon_en) begin
      prev_led  = '0;
      prev_busy = 1'b0;
      cur_ticks = 0;
    end else begin
      if (prev_busy && prev_led != '0 && bus.Tick) cur_ticks++;
      if (prev_busy && prev_led != '0 && (!bus.Busy || bus.LED != prev_led)) begin
        mon_cmp(1'b0, prev_led, cur_ticks);
        seg_count++;
        cur_ticks = 0;
      end
      if (bus.Done) mon_cmp(1'b1, bus.LED, int'(bus.Busy));
      prev_led  = bus.LED;
      prev_busy = bus.Busy;
    end
  end

  // One clock: advance to the falling edge and drive Tick with spacing >= 2 cycles
  task automatic cyc();
    @(negedge Sys_CLK);
    if (tick_en && gap == 0) begin
      bus.Tick = 1'b1;
      gap = int'($urandom_range(4, 1));
    end else begin
      bus.Tick = 1'b0;
      if (gap > 0) gap--;
    end
  endtask

  task automatic wr(logic [LED_W-1:0] l, int unsigned d);
    ent_t e;
    bus.Wr_En  = 1'b1;
    bus.Wr_Led = l;
    bus.Wr_Dur = DUR_W'(d);
    cyc();
    bus.Wr_En  = 1'b0;
    if (m_ent.size() < DEPTH) begin
      e.led = l;
      e.dur = d;
      m_ent.push_back(e);
    end
  endtask

  task automatic clr();
    bus.Clr = 1'b1;
    cyc();
    bus.Clr = 1'b0;
    m_ent.delete();
  endtask

  task automatic play();
    bus.Play = 1'b1;
    cyc();
    bus.Play = 1'b0;
  endtask

  // Reference: each pass shows every entry for max(dur,1) ticks, then one Done
  task automatic expect_play(int passes);
    for (int p = 0; p < passes; p++)
      foreach (m_ent[k]) push_ev(1'b0, m_ent[k].led, (m_ent[k].dur == 0) ? 1 : m_ent[k].dur);
    push_ev(1'b1, '0, 0);
  endtask

  task automatic drain(string name);
    int n = 0;
    while ((exp_q.size() != 0 || bus.Busy) && n < 3000) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Random entries: nonzero patterns, neighbours (and last vs first) distinct
  task automatic fill(int n, int unsigned dmax);
    logic [LED_W-1:0] l, prev, first;
    prev  = '0;
    first = '0;
    clr();
    for (int i = 0; i < n; i++) begin
      do l = LED_W'($urandom_range(15, 1));
      while (l == prev || (i == n - 1 && l == first));
      if (i == 0) first = l;
      prev = l;
      wr(l, $urandom_range(dmax, 0));
    end
  endtask

  initial begin
    int base, t;
    bus.Tick = 1'b0; bus.Wr_En = 1'b0; bus.Wr_Led = '0; bus.Wr_Dur = '0;
    bus.Clr = 1'b0; bus.Play = 1'b0; bus.Stop = 1'b0; bus.Loop = 1'b0;
    #2 Sys_RST = 1'b0;
    repeat (3) @(negedge Sys_CLK);
    chk("reset_led", int'(bus.LED), 0);
    chk("reset_busy", int'(bus.Busy), 0);
    chk("reset_done", int'(bus.Done), 0);
    chk("reset_count", int'(bus.Count), 0);
    chk("reset_full", int'(bus.Full), 0);
    Sys_RST = 1'b1;
    mon_en  = 1'b1;
    cyc();
    tick_en = 1'b1;

    // Two-entry replay with latency checks
    wr(4'b0001, 3);
    wr(4'b0010, 2);
    chk("count_two", int'(bus.Count), 2);
    expect_play(1);
    play();
    chk("play_busy_latency", int'(bus.Busy), 1);
    chk("play_led_in_load", int'(bus.LED), 0);
    cyc();
    chk("play_led_entry0", int'(bus.LED), 1);
    drain("basic_drain");
    chk("basic_end_led", int'(bus.LED), 0);
    chk("basic_end_busy", int'(bus.Busy), 0);

    // Fill to capacity, drop the overflow write, replay all 16
    clr();
    for (int i = 0; i < 16; i++) wr(LED_W'((i % 15) + 1), $urandom_range(2, 0));
    chk("full_count", int'(bus.Count), 16);
    chk("full_flag", int'(bus.Full), 1);
    wr(4'hF, 1);
    chk("overflow_count", int'(bus.Count), 16);
    expect_play(1);
    play();
    drain("full_drain");

    // Looping: three passes, Loop dropped during the last entry of pass three
    fill(3, 4);
    bus.Loop = 1'b1;
    expect_play(3);
    base = seg_count;
    play();
    t = 0;
    while (seg_count - base < 8 && t < 3000) begin
      cyc();
      t++;
    end
    chk("loop_reach_pass3", int'(seg_count - base >= 8), 1);
    bus.Loop = 1'b0;
    drain("loop_drain");

    // Stop after the first tick of entry0: no Done, outputs clear next cycle
    clr();
    wr(4'd5, 6);
    wr(4'd6, 2);
    push_ev(1'b0, 4'd5, 1);
    play();
    t = 0;
    while (!(cur_ticks == 1 && prev_led == 4'd5 && bus.Tick == 1'b0) && t < 500) begin
      cyc();
      t++;
    end
    tick_en  = 1'b0;
    bus.Stop = 1'b1;
    cyc();
    bus.Stop = 1'b0;
    chk("stop_led", int'(bus.LED), 0);
    chk("stop_busy", int'(bus.Busy), 0);
    chk("stop_done", int'(bus.Done), 0);
    repeat (3) cyc();
    chk("stop_events", exp_q.size(), 0);
    bus.Play = 1'b1;
    bus.Stop = 1'b1;
    cyc();
    bus.Play = 1'b0;
    bus.Stop = 1'b0;
    chk("play_stop_busy", int'(bus.Busy), 0);
    cyc();
    chk("play_stop_done", int'(bus.Done), 0);
    tick_en = 1'b1;

    // Zero duration holds for one tick; empty-buffer Play pulses Done
    clr();
    wr(4'd9, 0);
    wr(4'd10, 1);
    expect_play(1);
    play();
    drain("zero_dur_drain");
    clr();
    push_ev(1'b1, '0, 0);
    play();
    chk("empty_done", int'(bus.Done), 1);
    chk("empty_led", int'(bus.LED), 0);
    cyc();
    chk("empty_done_once", int'(bus.Done), 0);
    drain("empty_drain");

    // Clr beats Wr_En in idle; both ignored while playing
    wr(4'd3, 2);
    bus.Clr = 1'b1; bus.Wr_En = 1'b1; bus.Wr_Led = 4'd8; bus.Wr_Dur = 16'd1;
    cyc();
    bus.Clr = 1'b0; bus.Wr_En = 1'b0;
    m_ent.delete();
    chk("clr_over_wr", int'(bus.Count), 0);
    wr(4'd3, 4);
    wr(4'd4, 3);
    expect_play(1);
    play();
    cyc();
    bus.Clr = 1'b1; bus.Wr_En = 1'b1;
    cyc();
    bus.Clr = 1'b0; bus.Wr_En = 1'b0;
    chk("busy_clr_wr_count", int'(bus.Count), 2);
    drain("busy_clr_drain");

    // Async reset mid-replay
    clr();
    wr(4'd7, 8);
    play();
    cyc();
    cyc();
    mon_en = 1'b0;
    #2 Sys_RST = 1'b0;
    #1;
    chk("rst_mid_led", int'(bus.LED), 0);
    chk("rst_mid_count", int'(bus.Count), 0);
    chk("rst_mid_busy", int'(bus.Busy), 0);
    m_ent.delete();
    exp_q.delete();
    @(negedge Sys_CLK);
    Sys_RST = 1'b1;
    cyc();
    mon_en = 1'b1;
    cyc();

    // Random replays
    for (int r = 0; r < 5; r++) begin
      fill(int'($urandom_range(6, 2)), 5);
      chk("rand_count", int'(bus.Count), m_ent.size());
      expect_play(1);
      play();
      drain("rand_drain");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1);
  end
endmodule
